// File: rtl/display_capture_pkg.sv
// Shared constants for the scanned 7-segment display capture block:
// FSM state encodings, one-hot digit enables and the segment glyph table.
package display_capture_pkg;

    // Scan-tracking FSM states
    localparam logic [0:0] ST_HUNT  = 1'b0;
    localparam logic [0:0] ST_TRACK = 1'b1;

    // Digit enable encodings (bit k = digit k)
    localparam logic [3:0] ED_BLANK = 4'b0000;
    localparam logic [3:0] ED_DIG0  = 4'b0001;
    localparam logic [3:0] ED_DIG1  = 4'b0010;
    localparam logic [3:0] ED_DIG2  = 4'b0100;
    localparam logic [3:0] ED_DIG3  = 4'b1000;

    // Segment patterns (gfedcba) for hex values 0..F, indexed by value
    localparam logic [6:0] SEG_PATTERN [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    // True when exactly one enable bit is set
    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational segment-pattern to hex-digit lookup. Patterns outside the
// glyph table decode to 0 with o_ok low.
module seg7_decode
    import display_capture_pkg::*;
(
    input  logic [6:0] i_seg,
    output logic [3:0] o_hex,
    output logic       o_ok
);

    // Table search; glyphs are unique so at most one entry matches
    always_comb begin
        o_hex = 4'd0;
        o_ok  = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i_seg == SEG_PATTERN[i]) begin
                o_hex = 4'(i);
                o_ok  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/display_scan_capture.sv
// Capture side of a scanned 7-segment display bus. Synchronizes and
// glitch-filters {ED_in, D_in}, latches each digit's pattern, tracks the
// 0->1->2->3 scan order and drops lock on framing errors or scan loss.
// Optional macro DISPLAY_CAPTURE_HEX_EN adds per-digit hex decode outputs.
module display_scan_capture
    import display_capture_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] ED_in,
    input  logic [6:0] D_in,
    output logic [6:0] D0,
    output logic [6:0] D1,
    output logic [6:0] D2,
    output logic [6:0] D3,
    output logic       frame_valid,
    output logic       frame_stb,
    output logic       seq_err
`ifdef DISPLAY_CAPTURE_HEX_EN
    ,
    output logic [3:0] hex0,
    output logic [3:0] hex1,
    output logic [3:0] hex2,
    output logic [3:0] hex3,
    output logic [3:0] hex_ok
`endif
);

    // Stability counter holds up to STABLE_CYCLES+1 ("already accepted")
    localparam int unsigned SCW = $clog2(STABLE_CYCLES + 2);
    localparam int unsigned TOW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SCW-1:0] STAB_ACCEPT = SCW'(STABLE_CYCLES);
    localparam logic [SCW-1:0] STAB_DONE   = SCW'(STABLE_CYCLES + 1);
    localparam logic [TOW-1:0] TO_MAX      = TOW'(TIMEOUT_CYCLES);

    logic [10:0]    r_sync1;
    logic [10:0]    r_sync2;
    logic [SCW-1:0] r_stab_cnt;
    logic [TOW-1:0] r_to_cnt;
    logic [0:0]     r_state;
    logic [1:0]     r_exp;
    logic           r_frame_valid;
    logic           r_frame_stb;
    logic           r_seq_err;
    logic [6:0]     r_digit [4];

    logic [3:0]     w_ed;
    logic [6:0]     w_seg;
    logic           w_accept;
    logic           w_acc_onehot;
    logic           w_acc_multi;
    logic [1:0]     w_idx;
    logic [6:0]     w_digit_d [4];
    logic [TOW-1:0] w_to_d;
    logic [0:0]     w_state_d;
    logic [1:0]     w_exp_d;
    logic           w_fv_d;
    logic           w_stb_d;
    logic           w_err_d;

    assign w_ed  = r_sync2[10:7];
    assign w_seg = r_sync2[6:0];

    // Accept exactly once, when the word has been held STABLE_CYCLES cycles
    assign w_accept     = (r_stab_cnt == STAB_ACCEPT);
    assign w_acc_onehot = w_accept && is_onehot4(w_ed);
    assign w_acc_multi  = w_accept && (w_ed != ED_BLANK) && !is_onehot4(w_ed);

    // Two-flop synchronizer on the whole 11-bit bus word
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sync1 <= 11'd0;
            r_sync2 <= 11'd0;
        end else begin
            r_sync1 <= {ED_in, D_in};
            r_sync2 <= r_sync1;
        end
    end

    // Stability counter: restarts at 1 on the edge a new word reaches r_sync2
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_stab_cnt <= '0;
        end else if (r_sync1 != r_sync2) begin
            r_stab_cnt <= SCW'(1);
        end else if (r_stab_cnt != STAB_DONE) begin
            r_stab_cnt <= r_stab_cnt + 1'b1;
        end
    end

    // Digit index of a one-hot enable
    always_comb begin
        w_idx = 2'd0;
        case (w_ed)
            ED_DIG1: w_idx = 2'd1;
            ED_DIG2: w_idx = 2'd2;
            ED_DIG3: w_idx = 2'd3;
            default: w_idx = 2'd0;
        endcase
    end

    // Next value of each digit register
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            w_digit_d[k] = r_digit[k];
            if (w_acc_onehot && (w_idx == 2'(k))) begin
                w_digit_d[k] = w_seg;
            end
        end
    end

    // Scan-order FSM, lock flag, pulses and scan-loss timeout
    always_comb begin
        w_state_d = r_state;
        w_exp_d   = r_exp;
        w_fv_d    = r_frame_valid;
        w_stb_d   = 1'b0;
        w_err_d   = 1'b0;
        w_to_d    = r_to_cnt;
        if (r_to_cnt != TO_MAX) begin
            w_to_d = r_to_cnt + 1'b1;
        end

        if (w_acc_onehot) begin
            // An accept on the same edge as a timeout takes priority
            w_to_d = '0;
            if (r_state == ST_HUNT) begin
                if (w_idx == 2'd0) begin
                    w_state_d = ST_TRACK;
                    w_exp_d   = 2'd1;
                end
            end else if (w_idx == r_exp) begin
                if (w_idx == 2'd3) begin
                    w_stb_d = 1'b1;
                    w_fv_d  = 1'b1;
                    w_exp_d = 2'd0;
                end else begin
                    w_exp_d = r_exp + 2'd1;
                end
            end else begin
                w_err_d = 1'b1;
                w_fv_d  = 1'b0;
                if (w_idx == 2'd0) begin
                    w_exp_d = 2'd1;
                end else begin
                    w_state_d = ST_HUNT;
                    w_exp_d   = 2'd0;
                end
            end
        end else if (w_acc_multi) begin
            w_err_d   = 1'b1;
            w_fv_d    = 1'b0;
            w_state_d = ST_HUNT;
            w_exp_d   = 2'd0;
        end else if (r_to_cnt == TO_MAX) begin
            w_fv_d    = 1'b0;
            w_state_d = ST_HUNT;
            w_exp_d   = 2'd0;
        end
    end

    // Control and digit state registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= ST_HUNT;
            r_exp         <= 2'd0;
            r_frame_valid <= 1'b0;
            r_frame_stb   <= 1'b0;
            r_seq_err     <= 1'b0;
            r_to_cnt      <= '0;
            for (int k = 0; k < 4; k++) begin
                r_digit[k] <= 7'h00;
            end
        end else begin
            r_state       <= w_state_d;
            r_exp         <= w_exp_d;
            r_frame_valid <= w_fv_d;
            r_frame_stb   <= w_stb_d;
            r_seq_err     <= w_err_d;
            r_to_cnt      <= w_to_d;
            for (int k = 0; k < 4; k++) begin
                r_digit[k] <= w_digit_d[k];
            end
        end
    end

    assign D0          = r_digit[0];
    assign D1          = r_digit[1];
    assign D2          = r_digit[2];
    assign D3          = r_digit[3];
    assign frame_valid = r_frame_valid;
    assign frame_stb   = r_frame_stb;
    assign seq_err     = r_seq_err;

`ifdef DISPLAY_CAPTURE_HEX_EN
    logic [3:0] w_hex [4];
    logic [3:0] w_hex_ok;
    logic [3:0] r_hex [4];
    logic [3:0] r_hex_ok;

    // Decode the next digit value so hex lands on the same edge as Dk
    for (genvar k = 0; k < 4; k++) begin : g_dec
        seg7_decode u_dec (
            .i_seg (w_digit_d[k]),
            .o_hex (w_hex[k]),
            .o_ok  (w_hex_ok[k])
        );
    end

    // Hex output registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_hex_ok <= 4'd0;
            for (int k = 0; k < 4; k++) begin
                r_hex[k] <= 4'd0;
            end
        end else begin
            r_hex_ok <= w_hex_ok;
            for (int k = 0; k < 4; k++) begin
                r_hex[k] <= w_hex[k];
            end
        end
    end

    assign hex0   = r_hex[0];
    assign hex1   = r_hex[1];
    assign hex2   = r_hex[2];
    assign hex3   = r_hex[3];
    assign hex_ok = r_hex_ok;
`endif

endmodule

// File: tb/tb_display_scan_capture.sv
// Bench for display_scan_capture: directed bus vectors, expected
// frame_stb/seq_err events queued by the stimulus and popped by a monitor.
module tb_display_scan_capture;

    logic       clock;
    logic       reset;
    logic [3:0] ED_in;
    logic [6:0] D_in;
    logic [6:0] D0;
    logic [6:0] D1;
    logic [6:0] D2;
    logic [6:0] D3;
    logic       frame_valid;
    logic       frame_stb;
    logic       seq_err;
`ifdef DISPLAY_CAPTURE_HEX_EN
    logic [3:0] hex0;
    logic [3:0] hex1;
    logic [3:0] hex2;
    logic [3:0] hex3;
    logic [3:0] hex_ok;
`endif

    int n_pass  = 0;
    int n_total = 0;

    // Event word: {stb, err, frame_valid, D0, D1, D2, D3}
    typedef logic [30:0] ev_t;
    ev_t exp_q[$];
    ev_t mon_act;
    ev_t mon_req;

    display_scan_capture #(
        .STABLE_CYCLES  (4),
        .TIMEOUT_CYCLES (32)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .ED_in       (ED_in),
        .D_in        (D_in),
        .D0          (D0),
        .D1          (D1),
        .D2          (D2),
        .D3          (D3),
        .frame_valid (frame_valid),
        .frame_stb   (frame_stb),
        .seq_err     (seq_err)
`ifdef DISPLAY_CAPTURE_HEX_EN
        ,
        .hex0        (hex0),
        .hex1        (hex1),
        .hex2        (hex2),
        .hex3        (hex3),
        .hex_ok      (hex_ok)
`endif
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic ev_t mk(input logic stb, input logic err, input logic fv,
                               input logic [6:0] d0, input logic [6:0] d1,
                               input logic [6:0] d2, input logic [6:0] d3);
        return {stb, err, fv, d0, d1, d2, d3};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h", name, act, req);
    endtask

    // Drive one bus word and hold it for n cycles (called at a negedge)
    task automatic put(input logic [3:0] ed, input logic [6:0] d, input int n);
        ED_in = ed;
        D_in  = d;
        repeat (n) @(negedge clock);
    endtask

    task automatic frame(input logic [6:0] a, input logic [6:0] b,
                         input logic [6:0] c, input logic [6:0] e);
        put(4'b0001, a, 8);
        put(4'b0010, b, 8);
        put(4'b0100, c, 8);
        put(4'b1000, e, 8);
    endtask

    // Monitor: every pulse on frame_stb/seq_err must match the next queued event
    always @(negedge clock) begin
        if (!reset && (frame_stb === 1'b1 || seq_err === 1'b1)) begin
            n_total++;
            mon_act = {frame_stb, seq_err, frame_valid, D0, D1, D2, D3};
            if (exp_q.size() == 0) begin
                $display("FAIL event_unexpected actual=%h required=none", mon_act);
            end else begin
                mon_req = exp_q.pop_front();
                if (mon_act === mon_req) n_pass++;
                else $display("FAIL event actual=%h required=%h", mon_act, mon_req);
            end
        end
    end

    initial begin
        int waited;
        reset = 1'b1;
        ED_in = 4'd0;
        D_in  = 7'd0;
        repeat (3) @(negedge clock);
        check("rst_D0", 32'(D0), 32'h00);
        check("rst_D3", 32'(D3), 32'h00);
        check("rst_fv", 32'(frame_valid), 32'h0);
        check("rst_stb", 32'(frame_stb), 32'h0);
        check("rst_err", 32'(seq_err), 32'h0);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // Basic in-order frame
        exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 7'h3F, 7'h06, 7'h5B, 7'h4F));
        frame(7'h3F, 7'h06, 7'h5B, 7'h4F);
        check("f1_D0", 32'(D0), 32'h3F);
        check("f1_D1", 32'(D1), 32'h06);
        check("f1_D2", 32'(D2), 32'h5B);
        check("f1_D3", 32'(D3), 32'h4F);
        check("f1_fv", 32'(frame_valid), 32'h1);

        // One-cycle glitch inside the digit-1 dwell is filtered out
        exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 7'h3F, 7'h06, 7'h5B, 7'h4F));
        put(4'b0001, 7'h3F, 8);
        put(4'b0010, 7'h06, 3);
        put(4'b0010, 7'h7F, 1);
        put(4'b0010, 7'h06, 8);
        check("glitch_D1", 32'(D1), 32'h06);
        put(4'b0100, 7'h5B, 8);
        put(4'b1000, 7'h4F, 8);

        // Skip from digit 0 to digit 2, then relock
        exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 7'h3F, 7'h06, 7'h66, 7'h4F));
        put(4'b0001, 7'h3F, 8);
        put(4'b0100, 7'h66, 8);
        check("order_fv", 32'(frame_valid), 32'h0);
        exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 7'h07, 7'h7F, 7'h6F, 7'h77));
        frame(7'h07, 7'h7F, 7'h6F, 7'h77);

        // Multi-hot enable errors; blanking is ignored
        exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 7'h07, 7'h7F, 7'h6F, 7'h77));
        put(4'b0011, 7'h7D, 8);
        put(4'b0000, 7'h7C, 8);
        check("multi_D0", 32'(D0), 32'h07);
        check("multi_D1", 32'(D1), 32'h7F);
        check("multi_fv", 32'(frame_valid), 32'h0);

        // Lock, then freeze the bus until the scan-loss timeout
        exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 7'h3F, 7'h06, 7'h5B, 7'h4F));
        frame(7'h3F, 7'h06, 7'h5B, 7'h4F);
        check("to_locked", 32'(frame_valid), 32'h1);
        waited = 0;
        while (frame_valid === 1'b1 && waited < 80) begin
            @(negedge clock);
            waited++;
        end
        check("to_fv_fell", 32'(frame_valid), 32'h0);
        check("to_delay_ok", 32'(waited >= 28 && waited <= 34), 32'h1);
        check("to_D0_hold", 32'(D0), 32'h3F);
        check("to_D3_hold", 32'(D3), 32'h4F);

        // Relock, then reset asynchronously in the middle of the next frame
        exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 7'h3F, 7'h06, 7'h5B, 7'h4F));
        frame(7'h3F, 7'h06, 7'h5B, 7'h4F);
        put(4'b0001, 7'h6D, 8);
        put(4'b0010, 7'h7D, 8);
        check("mid_D1_pre", 32'(D1), 32'h7D);
        #2 reset = 1'b1;
        #1;
        check("arst_D0", 32'(D0), 32'h00);
        check("arst_D1", 32'(D1), 32'h00);
        check("arst_D2", 32'(D2), 32'h00);
        check("arst_fv", 32'(frame_valid), 32'h0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;

        // Partial frame after reset must not lock
        put(4'b0010, 7'h7D, 8);
        put(4'b0100, 7'h5B, 8);
        put(4'b1000, 7'h4F, 8);
        check("post_rst_fv", 32'(frame_valid), 32'h0);
        check("post_rst_D1", 32'(D1), 32'h7D);
        exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 7'h77, 7'h06, 7'h5B, 7'h01));
        frame(7'h77, 7'h06, 7'h5B, 7'h01);
        check("relock_fv", 32'(frame_valid), 32'h1);
`ifdef DISPLAY_CAPTURE_HEX_EN
        check("hex0_A", 32'(hex0), 32'hA);
        check("hex_ok0", 32'(hex_ok[0]), 32'h1);
        check("hex3_bad", 32'(hex3), 32'h0);
        check("hex_ok3", 32'(hex_ok[3]), 32'h0);
`endif

        repeat (4) @(negedge clock);
        check("events_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
